// File: rtl/bcd_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder_pkg
// Description : Shared FSM state encoding and BCD constants for the
//               digit-serial BCD adder.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;   // digits per operand
    localparam int BCD_MAX    = 9;   // largest legal BCD digit
    localparam int BCD_ADJ    = 6;   // decimal correction added on overflow

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : Combinational single-digit BCD adder with carry in/out.
//               Operand digits above 9 are not rejected; the same
//               correction rule is applied to whatever sum they produce.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_t;

    assign w_t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

    // Binary sum above 9 wraps into the next decade: add 6, keep low nibble
    always_comb begin
        if (w_t > 5'(BCD_MAX)) begin
            s    = w_t[3:0] + 4'(BCD_ADJ);
            cout = 1'b1;
        end else begin
            s    = w_t[3:0];
            cout = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder
// Description : Four-digit packed-BCD adder processing one digit per clock,
//               least-significant digit first, through one shared digit adder.
//               Optional macro BCD_INPUT_CHECK_EN enables a sticky flag for
//               operand digits above 9; otherwise err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        err
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_sum;
    logic        r_carry;
    logic        r_cout;
    logic [1:0]  r_idx;
    logic [3:0]  w_da;
    logic [3:0]  w_db;
    logic [3:0]  w_s;
    logic        w_c;
    logic        w_last;
    logic        w_accept;
    logic        w_in_add;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_in_add = (r_state == ST_ADD);
    assign w_last   = (r_idx == 2'(NUM_DIGITS - 1));
    assign w_da     = r_a[{r_idx, 2'b00} +: 4];
    assign w_db     = r_b[{r_idx, 2'b00} +: 4];

    bcd_digit_add u_digit (
        .a    (w_da),
        .b    (w_db),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: start only honoured in IDLE, four ADD cycles, one DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_ADD;
            ST_ADD:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch and digit-serial datapath; sum/cout hold outside ADD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_sum   <= 16'h0000;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= 2'd0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
            r_idx   <= 2'd0;
        end else if (w_in_add) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_s;
            r_carry <= w_c;
            r_idx   <= r_idx + 2'd1;
            if (w_last) r_cout <= w_c;
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic r_err;
    logic w_bad;

    assign w_bad = (w_da > 4'(BCD_MAX)) || (w_db > 4'(BCD_MAX));

    // Sticky illegal-digit flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_err <= 1'b0;
        else if (w_accept) r_err <= 1'b0;
        else if (w_in_add) r_err <= r_err | w_bad;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign busy = w_in_add;
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_adder
// Description : Self-checking bench for bcd_serial_adder with a scoreboard
//               of expected results; follows BCD_INPUT_CHECK_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int   tests;
    int   fails;
    exp_t sb[$];

`ifdef BCD_INPUT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    bcd_serial_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Issue one operation (caller is away from posedge) and observe until done.
    // Optionally re-drive start with a=16'h1111 at ADD cycle 'poke' (0 = never).
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input int poke,
                         output bit seen, output int lat, output int busy_n,
                         output logic [15:0] osum, output logic ocout, output logic oerr,
                         output logic done_next);
        seen = 0; lat = 0; busy_n = 0; osum = '0; ocout = 0; oerr = 0; done_next = 1'b1;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            lat++;
            if (busy) busy_n++;
            if (lat == poke) begin
                a = 16'h1111; b = 16'h1111; start = 1'b1;
            end
            if (done) begin
                seen = 1; osum = sum; ocout = cout; oerr = err;
                break;
            end
        end
        start = 1'b0;
        if (seen) begin
            @(posedge clk); #1;
            done_next = done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0",
                     busy, done, sum, cout, err);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Common body: push expectation, run, pop, compare inline
    task automatic test_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input exp_t e, input int poke);
        bit seen; int lat; int bn; logic [15:0] s; logic c; logic er; logic dn;
        exp_t x;
        sb.push_back(e);
        do_op(ta, tb_, tc, poke, seen, lat, bn, s, c, er, dn);
        x = sb.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_timeout: no done within 20 cycles, want done", nm);
            return;
        end
        if (s !== x.sum || c !== x.cout || er !== x.err) begin
            fails++;
            $display("FAIL %s_result: got sum=%h cout=%b err=%b, want sum=%h cout=%b err=%b",
                     nm, s, c, er, x.sum, x.cout, x.err);
        end
        tests++;
        if (lat != 5) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles, want 5", nm, lat);
        end
        tests++;
        if (bn != 4) begin
            fails++;
            $display("FAIL %s_busy: got %0d busy cycles, want 4", nm, bn);
        end
        tests++;
        if (dn !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_pulse: done after pulse=%b, want 0", nm, dn);
        end
    endtask

    task automatic test_basic();
        test_op("basic", 16'h1234, 16'h5678, 1'b0, '{16'h6912, 1'b0, 1'b0}, 0);
        // result held in IDLE
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sum !== 16'h6912 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL hold_idle: got sum=%h cout=%b busy=%b done=%b, want 6912 0 0 0",
                     sum, cout, busy, done);
        end
    endtask

    task automatic test_ripple();
        test_op("ripple", 16'h9999, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0);
    endtask

    // Second op driven in the IDLE cycle straight after DONE (do_op ends there)
    task automatic test_back_to_back();
        test_op("cin_only", 16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}, 0);
        test_op("b2b", 16'h5000, 16'h5000, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0);
    endtask

    task automatic test_ignore_start();
        test_op("ignore_start", 16'h1234, 16'h5678, 1'b0, '{16'h6912, 1'b0, 1'b0}, 2);
        // the poked start fell in ADD; DUT must now be idle, not restarted
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_restart: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_add();
        int dones;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;   // ADD cycle 1
        @(negedge clk);                 // ADD cycle 2
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, sum, cout, err} !== 20'h0) begin
            fails++;
            $display("FAIL reset_mid_add: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0",
                     busy, done, sum, cout, err);
        end
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
        end
        test_op("after_reset", 16'h0456, 16'h0789, 1'b1, '{16'h1246, 1'b0, 1'b0}, 0);
    endtask

    // Digit 1 = A: A+0 -> (10+6) mod 16 = 0, carry 1 -> sum 0100
    task automatic test_input_check();
        test_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, '{16'h0100, 1'b0, CHECK_EN}, 0);
        test_op("err_clear", 16'h0002, 16'h0003, 1'b0, '{16'h0005, 1'b0, 1'b0}, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [15:0] ra, rb; logic rc; int t; exp_t e;
            for (int d = 0; d < 4; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(0, 9));
                rb[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            t = bcd2int(ra) + bcd2int(rb) + int'(rc);
            e.sum = int2bcd(t % 10000); e.cout = (t >= 10000); e.err = 1'b0;
            test_op("random", ra, rb, rc, e, 0);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_add();
        test_input_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
